// File: rtl/hazard_pkg.sv
// Shared hazard-unit constants and types for the vector write scoreboard.
// Holds register/latency widths, default sizes and the latency clamp helper.
package hazard_pkg;
  localparam int REG_ADDR_W              = 5;
  localparam int LAT_W                   = 4;
  localparam int NREGS_DEFAULT           = 32;
  localparam int MAX_OUTSTANDING_DEFAULT = 8;
  localparam int OUTST_W                 = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]      lat_t;
  typedef logic [OUTST_W-1:0]    outst_t;

  // A zero latency still needs one cycle to reach writeback.
  function automatic lat_t effLat(input lat_t lat);
    return (lat == '0) ? lat_t'(1) : lat;
  endfunction
endpackage

// File: rtl/scoreboard_entry.sv
// One tracked register: countdown to writeback, busy flag and a retire pulse
// registered for the cycle after the counter reaches zero.
module scoreboard_entry
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  lat_t loadLat,
  output logic busy,
  output logic wbPulse,
  output logic retiring,
  output logic pendingGt1
);

  lat_t cnt;

  // A load on the retiring edge still emits the pulse for the old write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wbPulse <= 1'b0;
    end else begin
      wbPulse <= retiring;
      if (load) begin
        cnt <= effLat(loadLat);
      end else if (cnt != '0) begin
        cnt <= cnt - lat_t'(1);
      end
    end
  end

  assign busy       = (cnt != '0);
  assign retiring   = (cnt == lat_t'(1));
  assign pendingGt1 = (cnt > lat_t'(1));

endmodule

// File: rtl/vector_scoreboard.sv
// Vector register write scoreboard: tracks multi-cycle pending writes and
// raises stall_req for RAW/WAW/capacity hazards. Optional SCOREBOARD_FWD_EN.
module vector_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS           = NREGS_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dst,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic                  flushE,
  output logic                  stall_req,
  output logic [NREGS-1:0]      busy,
  output logic [NREGS-1:0]      wb_mask,
  output logic [OUTST_W-1:0]    outstanding,
  output logic                  full
);

  localparam int RCNT_W = $clog2(NREGS + 1);

  logic [NREGS-1:0] load;
  logic [NREGS-1:0] retiring;
  logic [NREGS-1:0] pendingGt1;
  logic             accept;
  logic             rsBlocked;
  logic             rtBlocked;
  logic             wawBlocked;
  logic             fullBlocked;
  logic [RCNT_W-1:0] retireCnt;
  outst_t           outstandingNext;

  // Handshake: issue_valid is held by D; an issue is taken on the rising edge
  // where issue_valid=1 and stall_req=0, unless flushE cancels it or dst is 0.
  always_comb begin
`ifdef SCOREBOARD_FWD_EN
    rsBlocked = pendingGt1[rsD];
    rtBlocked = pendingGt1[rtD];
`else
    rsBlocked = busy[rsD];
    rtBlocked = busy[rtD];
`endif
    wawBlocked  = pendingGt1[issue_dst];
    fullBlocked = full & ~(|retiring);
    stall_req   = issue_valid & (rsBlocked | rtBlocked | wawBlocked | fullBlocked);
    accept      = issue_valid & ~stall_req & ~flushE & (issue_dst != '0);
  end

  assign load[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_load
    assign load[i] = accept & (issue_dst == REG_ADDR_W'(i));
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_entry
    scoreboard_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .loadLat   (issue_lat),
      .busy      (busy[i]),
      .wbPulse   (wb_mask[i]),
      .retiring  (retiring[i]),
      .pendingGt1(pendingGt1[i])
    );
  end

  always_comb begin
    retireCnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      retireCnt = retireCnt + RCNT_W'(retiring[i]);
    end
    outstandingNext = outstanding + OUTST_W'(accept) - OUTST_W'(retireCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      full        <= 1'b0;
    end else begin
      outstanding <= outstandingNext;
      full        <= (outstandingNext == OUTST_W'(MAX_OUTSTANDING));
    end
  end

endmodule

// File: tb/tb_vector_scoreboard.sv
// Directed bench for vector_scoreboard with hand-computed expectations.
// Honours SCOREBOARD_FWD_EN for the forwarding release cycle.
module tb_vector_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic [3:0]  issue_lat;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic        flushE;
  logic        stall_req;
  logic [31:0] busy;
  logic [31:0] wb_mask;
  logic [3:0]  outstanding;
  logic        full;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  vector_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_dst  (issue_dst),
    .issue_lat  (issue_lat),
    .rsD        (rsD),
    .rtD        (rtD),
    .flushE     (flushE),
    .stall_req  (stall_req),
    .busy       (busy),
    .wb_mask    (wb_mask),
    .outstanding(outstanding),
    .full       (full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic [3:0] l,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl);
    issue_valid = v;
    issue_dst   = d;
    issue_lat   = l;
    rsD         = rs;
    rtD         = rt;
    flushE      = fl;
    #1;
  endtask

  initial begin
    logic [5:0] e;
    logic       exp_stall;
    rst = 1'b1;
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    check("rst_busy", busy, 32'h0);
    check("rst_wb", wb_mask, 32'h0);
    check("rst_out", 32'(outstanding), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    tick();

    // dst=5 lat=3: busy cycles 1-3, pulse cycle 4
    drive(1'b1, 5'd5, 4'd3, 5'd0, 5'd0, 1'b0);
    check("i5_stall", 32'(stall_req), 32'd0);
    tick();
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    exp_q.push_back({1'b0, 1'b0, 4'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lat3_seq", {26'd0, busy[5], wb_mask[5], outstanding}, 32'(e));
      tick();
    end

    // RAW on rsD=5 after dst=5 lat=4
    drive(1'b1, 5'd5, 4'd4, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 4'd1, 5'd5, 5'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
`ifdef SCOREBOARD_FWD_EN
      exp_stall = (k < 4);
`else
      exp_stall = (k <= 4);
`endif
      check($sformatf("raw_c%0d", k), 32'(stall_req), 32'(exp_stall));
      tick();
    end
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // dst=0 is never tracked
    drive(1'b1, 5'd0, 4'd5, 5'd0, 5'd0, 1'b0);
    check("d0_stall", 32'(stall_req), 32'd0);
    tick();
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    check("d0_busy", busy, 32'h0);
    check("d0_out", 32'(outstanding), 32'd0);

    // flushed issue is dropped
    drive(1'b1, 5'd7, 4'd2, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    check("flush_busy7", 32'(busy[7]), 32'd0);
    check("flush_out", 32'(outstanding), 32'd0);

    // WAW stall at cnt=2, reissue allowed at cnt=1
    drive(1'b1, 5'd7, 4'd2, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 4'd3, 5'd0, 5'd0, 1'b0);
    check("waw_stall", 32'(stall_req), 32'd1);
    tick();
    check("reiss_stall", 32'(stall_req), 32'd0);
    tick();
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    check("reiss_wb7", 32'(wb_mask[7]), 32'd1);
    check("reiss_busy7", 32'(busy[7]), 32'd1);
    check("reiss_out", 32'(outstanding), 32'd1);
    tick();
    tick();
    tick();
    check("reiss_end_wb", wb_mask, 32'h80);
    check("reiss_end_busy", busy, 32'h0);
    check("reiss_end_out", 32'(outstanding), 32'd0);
    tick();

    // fill with 8 long writes, then dst=9 waits for reg 1
    for (int r = 1; r <= 8; r++) begin
      drive(1'b1, 5'(r), 4'd15, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd9, 4'd2, 5'd0, 5'd0, 1'b0);
    check("fill_out", 32'(outstanding), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("full_stall%0d", k), 32'(stall_req), 32'd1);
      tick();
    end
    check("full_release", 32'(stall_req), 32'd0);
    tick();
    drive(1'b0, 5'd0, 4'd0, 5'd0, 5'd0, 1'b0);
    check("swap_out", 32'(outstanding), 32'd8);
    check("swap_full", 32'(full), 32'd1);
    check("swap_busy", busy, 32'h0000_03FC);
    check("swap_wb", wb_mask, 32'h2);

    // async reset with pending writes
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 32'h0);
    check("arst_wb", wb_mask, 32'h0);
    check("arst_out", 32'(outstanding), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("post_rst_wb%0d", k), wb_mask | busy, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_scoreboard.md
VECTOR_SCOREBOARD -- requirements
Module: vector_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of tracked registers (5-bit addresses).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, maximum simultaneously busy registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1  D-stage instruction wants to issue a multi-cycle vector write.
REQ-006 SHALL have port issue_dst  input  5  destination register of the issuing instruction.
REQ-007 SHALL have port issue_lat  input  4  cycles until result is written (0 treated as 1).
REQ-008 SHALL have ports rsD, rtD  input  5 each  source registers of the D-stage instruction.
REQ-009 SHALL have port flushE  input  1  issue-cancel from the hazard unit.
REQ-010 SHALL have port stall_req  output  1  combinational stall request to the hazard unit.
REQ-011 SHALL have port busy  output  NREGS  per-register pending-write flags.
REQ-012 SHALL have port wb_mask  output  NREGS  one-cycle pulse per register whose pending write retired.
REQ-013 SHALL have port outstanding  output  4  count of busy registers.
REQ-014 SHALL have port full  output  1  high when outstanding == MAX_OUTSTANDING.

Function
REQ-015 SHALL accept an issue on a rising edge iff issue_valid & !stall_req & !flushE & issue_dst != 0.
REQ-016 SHALL, on accepted issue, load the issue_dst counter with max(issue_lat,1) and set busy[issue_dst].
REQ-017 SHALL decrement every nonzero counter by 1 each cycle; counter reaching 0 clears busy and sets that wb_mask bit for exactly the following cycle.
REQ-018 SHALL never track register 0: busy[0], wb_mask[0] always 0; rsD/rtD/issue_dst of 0 never cause a stall.
REQ-019 SHALL assert stall_req when issue_valid and any of: rsD busy, rtD busy, issue_dst busy with counter > 1 (WAW), or full with no retirement this cycle.
REQ-020 SHALL allow issue to a register whose counter == 1 (retiring this edge): retirement pulse still produced, counter reloaded, busy stays 1.
REQ-021 SHALL update outstanding as +1 per accepted issue, -1 per retirement, both in the same cycle netting correctly; never wraps.
REQ-022 SHALL let flushE suppress the issue only; pending counters keep running.
REQ-023 SHALL produce stall_req combinationally from current state and inputs (zero latency); all other outputs registered.

Reset
REQ-024 SHALL, while rst high, force all counters 0, busy = 0, wb_mask = 0, outstanding = 0, full = 0, independent of clk.
REQ-025 SHALL discard all pending writes on reset mid-operation; no wb_mask pulse after reset release.

Configuration
REQ-026 SHALL support macro SCOREBOARD_FWD_EN; when defined, a source (rsD/rtD) whose counter == 1 does not cause stall (result forwarded from writeback path).
REQ-027 SHALL, without SCOREBOARD_FWD_EN, stall on any busy source until busy clears.

Structure
REQ-028 SHALL take REG_ADDR_W=5, LAT_W=4, NREGS and MAX_OUTSTANDING defaults from shared package hazard_pkg.
REQ-029 SHALL instantiate NREGS copies of sub-module scoreboard_entry (counter, busy, retire pulse per register).

Verification
REQ-030 Issue dst=5 lat=3 at cycle 0 -> busy[5]=1 cycles 1-3, wb_mask[5]=1 cycle 4 only, outstanding 1 then 0.
REQ-031 After dst=5 lat=4 issue, next instruction rsD=5 -> stall_req=1 until busy[5] clears (FWD_EN: released one cycle earlier).
REQ-032 Issue dst=0 lat=5 -> no state change, stall_req=0, outstanding stays 0.
REQ-033 Eight issues to regs 1-8 lat=15, ninth issue dst=9 -> full=1, stall_req=1; once reg 1 retires, dst=9 accepted same cycle, outstanding stays 8.
REQ-034 Issue dst=7 with flushE=1 -> busy[7]=0; issue dst=7 while counter==1 -> wb_mask[7] pulses and busy[7] stays 1.
REQ-035 Assert rst with 3 pending writes -> all outputs 0 immediately, no wb_mask pulse afterwards.
